// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/execute pipeline register with operand forwarding
//
// Purpose:
//   Holds one decoded instruction between decode and the execute-stage ALU.
//   The stage accepts a new instruction under a valid/ready handshake and
//   keeps it while execute applies backpressure. It also resolves rs1/rs2
//   forwarding from the EX/MEM and MEM/WB stages, then drives the ALU inputs.
//
// Optional feature macro: ID_EX_FWD_EN
//   Defined   : forwarding muxes (MEM over WB over stored) and hold-capture.
//   Undefined : operands come straight from the stored register-file values.
//               The mem_fwd_* and wb_fwd_* ports are present but ignored.
//
// Ports:
//   clk, reset_n                   rising-edge clock, async active-low reset
//   id_valid / id_ready            decode handshake
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm            datapath fields (XLEN)
//   id_rs1_idx, id_rs2_idx,
//   id_rd_idx                      register indices (REGIDX)
//   id_alu_op, id_alu_src,
//   id_use_pc, id_reg_write        control fields
//   flush                          kills held and incoming instruction
//   ex_ready / ex_valid            execute handshake
//   alu_in_1, alu_in_2, alu_op     ALU drive
//   ex_store_data                  forwarded rs2 value
//   ex_pc, ex_imm, ex_rd_idx       held fields
//   ex_reg_write                   held reg_write gated by ex_valid
//   mem_fwd_we/rd/data             EX/MEM result bypass
//   wb_fwd_we/rd/data              MEM/WB write-back bypass

module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter int          REGIDX    = 5,
  parameter logic [3:0]  BUBBLE_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REGIDX-1:0] id_rs1_idx,
  input  logic [REGIDX-1:0] id_rs2_idx,
  input  logic [REGIDX-1:0] id_rd_idx,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_use_pc,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_in_1,
  output logic [XLEN-1:0]   alu_in_2,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REGIDX-1:0] ex_rd_idx,
  output logic              ex_reg_write,
  input  logic              mem_fwd_we,
  input  logic [REGIDX-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REGIDX-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data
);

  logic              valid_q,     valid_d;
  logic [XLEN-1:0]   pc_q,        pc_d;
  logic [XLEN-1:0]   rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic [REGIDX-1:0] rs1_idx_q,   rs1_idx_d;
  logic [REGIDX-1:0] rs2_idx_q,   rs2_idx_d;
  logic [REGIDX-1:0] rd_idx_q,    rd_idx_d;
  logic [3:0]        alu_op_q,    alu_op_d;
  logic              alu_src_q,   alu_src_d;
  logic              use_pc_q,    use_pc_d;
  logic              reg_write_q, reg_write_d;

  logic              load;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  assign id_ready = !valid_q || ex_ready;
  assign load     = id_valid && id_ready;

`ifdef ID_EX_FWD_EN
  // x0 is hardwired to zero, so a write "to" it must never be bypassed.
  function automatic logic wb_hit(input logic [REGIDX-1:0] idx);
    return wb_fwd_we && (wb_fwd_rd != '0) && (wb_fwd_rd == idx);
  endfunction

  function automatic logic mem_hit(input logic [REGIDX-1:0] idx);
    return mem_fwd_we && (mem_fwd_rd != '0) && (mem_fwd_rd == idx);
  endfunction

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (mem_hit(rs1_idx_q))     fwd_rs1 = mem_fwd_data;
    else if (wb_hit(rs1_idx_q)) fwd_rs1 = wb_fwd_data;
    if (mem_hit(rs2_idx_q))     fwd_rs2 = mem_fwd_data;
    else if (wb_hit(rs2_idx_q)) fwd_rs2 = wb_fwd_data;
  end
`else
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  // Bypass ports stay on the boundary for a uniform pipeline interface.
  logic unused_fwd;
  assign unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                        wb_fwd_we, wb_fwd_rd, wb_fwd_data,
                        rs1_idx_q, rs2_idx_q};
`endif

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    rd_idx_d    = rd_idx_q;
    alu_op_d    = alu_op_q;
    alu_src_d   = alu_src_q;
    use_pc_d    = use_pc_q;
    reg_write_d = reg_write_q;

    if (flush) begin
      // Any instruction offered this cycle is dropped along with the held one.
      valid_d     = 1'b0;
      alu_op_d    = BUBBLE_OP;
      reg_write_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_idx_d   = id_rs1_idx;
      rs2_idx_d   = id_rs2_idx;
      rd_idx_d    = id_rd_idx;
      alu_op_d    = id_alu_op;
      alu_src_d   = id_alu_src;
      use_pc_d    = id_use_pc;
      reg_write_d = id_reg_write;
    end else if (ex_ready) begin
      valid_d     = 1'b0;
      alu_op_d    = BUBBLE_OP;
      reg_write_d = 1'b0;
    end else if (valid_q) begin
`ifdef ID_EX_FWD_EN
      // A value leaving WB while we stall would otherwise be lost: the
      // register file read was taken before that write landed.
      if (wb_fwd_we && (wb_fwd_rd != '0) && (wb_fwd_rd == rs1_idx_q))
        rs1_data_d = wb_fwd_data;
      if (wb_fwd_we && (wb_fwd_rd != '0) && (wb_fwd_rd == rs2_idx_q))
        rs2_data_d = wb_fwd_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      rd_idx_q    <= '0;
      alu_op_q    <= BUBBLE_OP;
      alu_src_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      rd_idx_q    <= rd_idx_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      use_pc_q    <= use_pc_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_in_1      = use_pc_q  ? pc_q  : fwd_rs1;
  assign alu_in_2      = alu_src_q ? imm_q : fwd_rs2;
  assign alu_op        = valid_q ? alu_op_q : BUBBLE_OP;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd_idx     = rd_idx_q;
  assign ex_reg_write  = reg_write_q && valid_q;

endmodule
